// File: rtl/heart_ctrl.sv
// Player heart sequencer for the battle phase: frame-paced movement clamped to the
// battle box, damage intake, invulnerability window with blink, and death.
module heart_ctrl #(
    parameter int STEP        = 5,
    parameter int PLAYER_W    = 31,
    parameter int PLAYER_H    = 27,
    parameter int START_X     = 305,
    parameter int START_Y     = 227,
    parameter int HP_MAX      = 3,
    parameter int INV_FRAMES  = 60,
    parameter int BLINK_SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       collision,
    input  logic [8:0] left_border,
    input  logic [8:0] right_border,
    input  logic [8:0] top_border,
    input  logic [8:0] bottom_border,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [1:0] hp,
    output logic       sprite_visible,
    output logic       hit_pulse,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        INV   = 2'd2,
        DEAD  = 2'd3
    } phase_t;

    localparam int CW = $clog2(INV_FRAMES + 1);
    localparam logic [10:0]   STEP11   = 11'(STEP);
    localparam logic [10:0]   W11      = 11'(PLAYER_W);
    localparam logic [10:0]   H11      = 11'(PLAYER_H);
    localparam logic [CW-1:0] INV_LOAD = CW'(INV_FRAMES);

    phase_t        state;
    logic [CW-1:0] inv_cnt;
    logic [CW-1:0] cnt_dec;
    logic [1:0]    hp_dec;

    logic [10:0] x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
    logic [9:0]  x_move, y_move;

    assign phase   = state;
    assign cnt_dec = (inv_cnt != '0) ? inv_cnt - CW'(1) : '0;
    assign hp_dec  = (hp != 2'd0) ? hp - 2'd1 : 2'd0;

    // Candidate positions for a move tick; 11-bit math keeps the clamps free of wrap-around.
    always_comb begin
        x_ext  = {1'b0, x_pos};
        y_ext  = {1'b0, y_pos};
        x_lo   = {2'b00, left_border};
        y_lo   = {2'b00, top_border};
        x_hi   = ({2'b00, right_border} >= W11) ? {2'b00, right_border} - W11 : '0;
        y_hi   = ({2'b00, bottom_border} >= H11) ? {2'b00, bottom_border} - H11 : '0;
        x_move = x_pos;
        y_move = y_pos;
        if (key_left && !key_right)
            x_move = (x_ext >= x_lo + STEP11) ? 10'(x_ext - STEP11) : 10'(x_lo);
        else if (key_right && !key_left)
            x_move = (x_ext + STEP11 <= x_hi) ? 10'(x_ext + STEP11) : 10'(x_hi);
        if (key_up && !key_down)
            y_move = (y_ext >= y_lo + STEP11) ? 10'(y_ext - STEP11) : 10'(y_lo);
        else if (key_down && !key_up)
            y_move = (y_ext + STEP11 <= y_hi) ? 10'(y_ext + STEP11) : 10'(y_hi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            x_pos          <= 10'(START_X);
            y_pos          <= 10'(START_Y);
            hp             <= 2'(HP_MAX);
            inv_cnt        <= '0;
            sprite_visible <= 1'b0;
            hit_pulse      <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                IDLE, DEAD: begin
                    if (start) begin
                        state          <= FIGHT;
                        x_pos          <= 10'(START_X);
                        y_pos          <= 10'(START_Y);
                        hp             <= 2'(HP_MAX);
                        inv_cnt        <= '0;
                        sprite_visible <= 1'b1;
                    end
                end
                FIGHT, INV: begin
                    if (frame_tick) begin
                        x_pos <= x_move;
                        y_pos <= y_move;
                    end
                    // A hit takes priority over the countdown, so the hit edge never eats a window tick.
                    if (state == FIGHT && collision) begin
                        hp        <= hp_dec;
                        hit_pulse <= 1'b1;
                        if (hp_dec == 2'd0) begin
                            state          <= DEAD;
                            sprite_visible <= 1'b1;
                        end else begin
                            state          <= INV;
                            inv_cnt        <= INV_LOAD;
                            sprite_visible <= ~INV_LOAD[BLINK_SHIFT];
                        end
                    end else if (state == INV && frame_tick) begin
                        inv_cnt <= cnt_dec;
                        if (cnt_dec == '0) begin
                            state          <= FIGHT;
                            sprite_visible <= 1'b1;
                        end else begin
                            sprite_visible <= ~cnt_dec[BLINK_SHIFT];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
